// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator.
//   - Default 640x480@60 timing (pixels / lines) and pixel clock divider
//   - Derived line / frame totals and counter widths
//   - rgb_t : one-bit-per-channel colour bundle
//   - cnt_width() : bits needed to hold 0..total-1 (never less than 1)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned H_VIS_DEF   = 32'd640;
    localparam int unsigned H_FP_DEF    = 32'd16;
    localparam int unsigned H_SYNC_DEF  = 32'd96;
    localparam int unsigned H_BP_DEF    = 32'd48;
    localparam int unsigned V_VIS_DEF   = 32'd480;
    localparam int unsigned V_FP_DEF    = 32'd10;
    localparam int unsigned V_SYNC_DEF  = 32'd2;
    localparam int unsigned V_BP_DEF    = 32'd33;
    localparam int unsigned PIX_DIV_DEF = 32'd2;

    localparam int unsigned H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Bits needed for a counter running 0..total-1.
    function automatic int unsigned cnt_width(input int unsigned total);
        int unsigned w;
        if (total <= 32'd2) begin
            w = 32'd1;
        end else begin
            w = $clog2(total);
        end
        return w;
    endfunction

    localparam int unsigned H_CW_DEF = cnt_width(H_TOTAL_DEF);
    localparam int unsigned V_CW_DEF = cnt_width(V_TOTAL_DEF);

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

endpackage

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Bundles the renderer coordinate interface and the VGA pin outputs.
//   master (timing generator): drives col/row/vnotactive/frame_start and the
//                              pins, receives the renderer colour bits.
//   slave  (renderer / board): drives red/green/blue, observes the rest.
// Signals:
//   red, green, blue        colour from the renderer (1 CLK after col/row)
//   col, row [31:0]         raster position
//   vnotactive              row is in vertical blanking
//   frame_start             one-CLK pulse after the (0,0) wrap
//   vga_r/g/b               colour pins, blanked outside the visible area
//   vga_hs_n, vga_vs_n      active-low sync pins
// ---------------------------------------------------------------------------
interface vga_timing_if;

    logic        red;
    logic        green;
    logic        blue;
    logic [31:0] col;
    logic [31:0] row;
    logic        vnotactive;
    logic        frame_start;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        vga_hs_n;
    logic        vga_vs_n;

    modport master (
        input  red, green, blue,
        output col, row, vnotactive, frame_start,
        output vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n
    );

    modport slave (
        output red, green, blue,
        input  col, row, vnotactive, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n
    );

endinterface

// File: rtl/pix_clk_en.sv
// ---------------------------------------------------------------------------
// pix_clk_en
// Pixel enable generator: a mod-PIX_DIV counter, pix_en high for one CLK
// whenever the counter is 0. PIX_DIV of 1 holds pix_en high.
// Ports:
//   CLK     system clock
//   RST     asynchronous active-low reset (counter returns to 0)
//   pix_en  pixel enable; high in the first CLK after reset release
// ---------------------------------------------------------------------------
module pix_clk_en #(
    parameter int unsigned PIX_DIV = 32'd2
) (
    input  logic CLK,
    input  logic RST,
    output logic pix_en
);

    generate
        if (PIX_DIV <= 32'd1) begin : g_bypass
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int unsigned DW = $clog2(PIX_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 32'd1);

            logic [DW-1:0] r_div;
            logic [DW-1:0] w_div_nxt;

            // Divider next value: wrap after PIX_DIV-1.
            always_comb begin
                w_div_nxt = r_div;
                if (r_div == DIV_LAST) begin
                    w_div_nxt = {DW{1'b0}};
                end else begin
                    w_div_nxt = r_div + DW'(32'd1);
                end
            end

            // Divider state register.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    r_div <= {DW{1'b0}};
                end else begin
                    r_div <= w_div_nxt;
                end
            end

            assign pix_en = (r_div == {DW{1'b0}});
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster timing generator for the display renderer. Produces the pixel
// position and blanking flag for the renderer, then re-times the renderer's
// colour (which arrives one CLK after col/row) together with the sync pulses
// so colour and sync reach the pins aligned, two CLKs after the counters.
// Ports:
//   CLK   system clock
//   RST   asynchronous active-low reset
//   bus   vga_timing_if.master: red/green/blue in; col, row, vnotactive,
//         frame_start, vga_r/g/b, vga_hs_n, vga_vs_n out
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS   = H_VIS_DEF,
    parameter int unsigned H_FP    = H_FP_DEF,
    parameter int unsigned H_SYNC  = H_SYNC_DEF,
    parameter int unsigned H_BP    = H_BP_DEF,
    parameter int unsigned V_VIS   = V_VIS_DEF,
    parameter int unsigned V_FP    = V_FP_DEF,
    parameter int unsigned V_SYNC  = V_SYNC_DEF,
    parameter int unsigned V_BP    = V_BP_DEF,
    parameter int unsigned PIX_DIV = PIX_DIV_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    vga_timing_if.master bus
);

    localparam int unsigned H_TOTAL    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW        = cnt_width(H_TOTAL);
    localparam int unsigned VCW        = cnt_width(V_TOTAL);
    localparam int unsigned H_SYNC_BEG = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    logic           w_pix_en;
    logic [HCW-1:0] r_col;
    logic [HCW-1:0] w_col_nxt;
    logic [VCW-1:0] r_row;
    logic [VCW-1:0] w_row_nxt;
    logic [31:0]    w_col32;
    logic [31:0]    w_row32;
    logic           w_col_last;
    logic           w_row_last;
    logic           w_h_act;
    logic           w_v_act;
    logic           w_hs_raw;
    logic           w_vs_raw;
    rgb_t           w_rgb_in;

    logic           r_hs_d;
    logic           r_vs_d;
    logic           r_act_d;
    logic           r_hs_n;
    logic           r_vs_n;
    logic           r_frame_start;
    rgb_t           r_rgb;

    pix_clk_en #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_clk_en (
        .CLK    (CLK),
        .RST    (RST),
        .pix_en (w_pix_en)
    );

    // Comparisons are done on the 32-bit zero-extended counters so the
    // timing constants never need truncating to the counter width.
    assign w_col32    = 32'(r_col);
    assign w_row32    = 32'(r_row);
    assign w_col_last = (w_col32 == (H_TOTAL - 32'd1));
    assign w_row_last = (w_row32 == (V_TOTAL - 32'd1));

    // Next raster position: line wrap and frame wrap share the same step.
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_col_last) begin
            w_col_nxt = {HCW{1'b0}};
            if (w_row_last) begin
                w_row_nxt = {VCW{1'b0}};
            end else begin
                w_row_nxt = r_row + VCW'(32'd1);
            end
        end else begin
            w_col_nxt = r_col + HCW'(32'd1);
            w_row_nxt = r_row;
        end
    end

    // Raster counters advance only on pixel enable and hold otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_col <= {HCW{1'b0}};
            r_row <= {VCW{1'b0}};
        end else if (w_pix_en) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    // Raw decode of the current position.
    assign w_h_act  = (w_col32 < H_VIS);
    assign w_v_act  = (w_row32 < V_VIS);
    assign w_hs_raw = (w_col32 >= H_SYNC_BEG) && (w_col32 < H_SYNC_END);
    assign w_vs_raw = (w_row32 >= V_SYNC_BEG) && (w_row32 < V_SYNC_END);
    assign w_rgb_in = '{r: bus.red, g: bus.green, b: bus.blue};

    // Frame start flags the CLK in which the counters first read (0,0).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en & w_col_last & w_row_last;
        end
    end

    // First output stage: delay the decode by one CLK so it lines up with
    // the renderer colour computed from the same col/row.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hs_d  <= 1'b0;
            r_vs_d  <= 1'b0;
            r_act_d <= 1'b0;
        end else begin
            r_hs_d  <= w_hs_raw;
            r_vs_d  <= w_vs_raw;
            r_act_d <= w_h_act & w_v_act;
        end
    end

    // Pin stage: colour masked by the aligned active flag, syncs inverted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hs_n <= 1'b1;
            r_vs_n <= 1'b1;
            r_rgb  <= '{r: 1'b0, g: 1'b0, b: 1'b0};
        end else begin
            r_hs_n <= ~r_hs_d;
            r_vs_n <= ~r_vs_d;
            r_rgb  <= w_rgb_in & {3{r_act_d}};
        end
    end

    assign bus.col         = w_col32;
    assign bus.row         = w_row32;
    assign bus.vnotactive  = ~w_v_act;
    assign bus.frame_start = r_frame_start;
    assign bus.vga_r       = r_rgb.r;
    assign bus.vga_g       = r_rgb.g;
    assign bus.vga_b       = r_rgb.b;
    assign bus.vga_hs_n    = r_hs_n;
    assign bus.vga_vs_n    = r_vs_n;

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator that drives the tic-tac-toe display renderer. It produces the pixel coordinates (`col`, `row`) and the `vnotactive` blanking flag consumed by the renderer. It re-times the renderer's registered colour bits together with the HSYNC/VSYNC pulses so that colour and sync reach the VGA connector pixel-aligned. It sits between the board clock and the physical VGA pins, and is the producing end of the renderer's coordinate interface.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `PIX_DIV`, 2, CLK cycles per pixel (≥1)
- `CLK`  in  1  system clock (50 MHz)
- `RST`  in  1  reset, asynchronous, active-low
- `red`, `green`, `blue`  in  1 each  colour from the renderer, registered one CLK after `col`/`row`
- `col`  out  32  horizontal pixel counter, 0..H_TOTAL-1
- `row`  out  32  vertical line counter, 0..V_TOTAL-1
- `vnotactive`  out  1  high while `row` ≥ V_VIS
- `frame_start`  out  1  one-CLK pulse when `row`/`col` wrap to (0,0)
- `vga_r`, `vga_g`, `vga_b`  out  1 each  colour to the pins, forced 0 outside the visible area
- `vga_hs_n`, `vga_vs_n`  out  1 each  active-low sync

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525).
- Pixel enable `pix_en`: a mod-PIX_DIV counter; `pix_en` is high for one CLK when the counter is 0. With PIX_DIV=1, `pix_en` is held high.
- On `pix_en`: `col` increments. At H_TOTAL-1, `col` becomes 0 and `row` increments. At `row`=V_TOTAL-1 and `col`=H_TOTAL-1, both become 0.
- `col` and `row` hold their values between `pix_en` pulses.
- Combinational raw flags, computed from the current counters:
  - `h_act` = `col` < H_VIS
  - `v_act` = `row` < V_VIS
  - `hs_raw` is asserted for H_VIS+H_FP ≤ `col` < H_VIS+H_FP+H_SYNC
  - `vs_raw` is asserted for the analogous `row` range
- `vnotactive` = !`v_act`. It is combinational from `row`, so it is valid in the same cycle as `row`.
- Output stage registers on every CLK:
  - `vga_hs_n` ← !`hs_raw`
  - `vga_vs_n` ← !`vs_raw`
  - `act_d` ← `h_act` & `v_act`
  - `vga_{r,g,b}` ← {red,green,blue} & {3{`act_d`}}
- `frame_start` is registered. It pulses in the CLK after the (0,0) transition.
- All counter arithmetic is unsigned, 32-bit wide at the ports. Internal counters are ⌈log2(TOTAL)⌉ bits, zero-extended to 32.

## Timing
- Reset values:
  - `col`=0, `row`=0, divider=0
  - `vnotactive`=0
  - `frame_start`=0
  - `vga_r/g/b`=0
  - `vga_hs_n`=1, `vga_vs_n`=1
  - `act_d`=0
- Reset mid-frame: every output returns to the reset values immediately (asynchronously). The first `pix_en` arrives in the first CLK after release.
- Latency:
  - `col`/`row` change → renderer colour valid: +1 CLK.
  - `act_d` and the sync flags are delayed by that same 1 CLK, so colour and sync leave the block aligned.
  - Pins lag the counters by 2 CLK. With PIX_DIV ≥ 2 this is within the same pixel period plus one CLK.
- Line wrap and frame wrap happen in the same `pix_en` cycle. There is no extra dead cycle.
- Sync pulse widths are exact: H_SYNC×PIX_DIV CLKs for HSYNC, and V_SYNC×H_TOTAL×PIX_DIV CLKs for VSYNC.

## Structure
- Package `vga_pkg`:
  - default 640×480@60 timing constants
  - derived H_TOTAL/V_TOTAL
  - counter width localparams
- Sub-module `pix_clk_en(CLK, RST, pix_en)`: parameterised PIX_DIV divider. Counters, decode and output registers stay in `vga_timing`.
- Expected size 120–200 lines.

## Test plan
- Reset release, PIX_DIV=2:
  - `col` steps 0,0,1,1,2… on CLK.
  - `row`=0.
  - `vga_hs_n`=`vga_vs_n`=1 for the first 1312 CLKs.
- Line timing: `vga_hs_n` falls 2 CLK after `col` reaches 656, stays low for exactly 192 CLKs, and the line period is 1600 CLKs.
- Frame timing:
  - `vnotactive` rises exactly when `row` = 480.
  - `vga_vs_n` is low for rows 490–491 (3200 CLKs).
  - `frame_start` pulses every 840000 CLKs.
- Blanking mask: hold `red`=`green`=`blue`=1.
  - `vga_r/g/b` = 1 only for `col` < 640 and `row` < 480, observed 2 CLK after the counters.
  - 0 elsewhere.
- Wrap: at `col`=799 and `row`=524, the next `pix_en` gives `col`=0 and `row`=0, with a single `frame_start` pulse. `row` never reads 525.
- Async reset asserted mid-frame (`row`=300, `col`=400): all outputs return to their reset values within the same cycle. The sequence restarts at (0,0) after release.
